// File: rtl/parity_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parity_link_pkg
// Purpose  : Shared definitions for the serial odd-parity frame link, used by
//            both the transmitter and the serial parity checker.
//            - FSM state encoding (IDLE/DATA/PARITY, 2'b11 treated as IDLE)
//            - default frame width
//            - parity-mode constants
//            - counter-width helper
// Revision : 1.0 - initial release
// ============================================================================
package parity_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10
    } state_e;

    localparam int FRAME_DATA_W = 3;

    localparam int PAR_EVEN_GEN = 0;
    localparam int PAR_ODD_GEN  = 1;

    // Width of a counter that must reach w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : parity_link_pkg
`default_nettype wire

// File: rtl/parity_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : parity_shift_reg
// Purpose  : Load/shift register feeding the serial transmitter.
//            On load, the first bit to send is returned on load_bit and the
//            register keeps the remaining DATA_W-1 bits; each shift moves the
//            next bit onto head. The transmitter's output flop therefore
//            always holds the bit on the line, and head is the bit to follow.
// Ports    : clk      - rising-edge clock
//            reset    - synchronous active-high reset (clears the register)
//            load     - capture din (takes priority over shift)
//            shift    - advance by one bit
//            din      - word to capture
//            load_bit - first bit of din in transmit order (combinational)
//            head     - next bit to be transmitted from the stored word
// Revision : 1.0 - initial release
// ============================================================================
module parity_shift_reg #(
    parameter int DATA_W    = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              load_bit,
    output logic              head
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_shift_val;

    generate
        if (DATA_W == 1) begin : g_single
            // The single bit goes straight to the line; nothing remains.
            assign load_bit    = din[0];
            assign w_load_val  = '0;
            assign w_shift_val = '0;
            assign head        = r_q[0];
        end else if (MSB_FIRST != 0) begin : g_msb
            assign load_bit    = din[DATA_W-1];
            assign w_load_val  = {din[DATA_W-2:0], 1'b0};
            assign w_shift_val = {r_q[DATA_W-2:0], 1'b0};
            assign head        = r_q[DATA_W-1];
        end else begin : g_lsb
            assign load_bit    = din[0];
            assign w_load_val  = {1'b0, din[DATA_W-1:1]};
            assign w_shift_val = {1'b0, r_q[DATA_W-1:1]};
            assign head        = r_q[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_load_val;
        end else if (shift) begin
            r_q <= w_shift_val;
        end
    end

endmodule : parity_shift_reg
`default_nettype wire

// File: rtl/parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : parity_serial_tx
// Purpose  : Transmit end of the serial parity frame link. Accepts a word via
//            valid/ready, sends DATA_W data bits one per clock, then one
//            parity bit. Back-to-back frames stream with no idle gap.
// Ports    : clk      - rising-edge clock
//            reset    - synchronous active-high reset (aborts any frame)
//            in_data  - word to transmit
//            in_valid - in_data is valid
//            in_ready - block can accept a word this cycle (IDLE or PARITY)
//            tx_bit   - serial line (registered)
//            tx_valid - tx_bit carries a frame bit (registered)
//            tx_par   - tx_bit is the parity bit (registered)
//            busy     - frame in progress
// Revision : 1.0 - initial release
// ============================================================================
module parity_serial_tx
    import parity_link_pkg::*;
#(
    parameter int DATA_W    = FRAME_DATA_W,
    parameter int PAR_ODD   = PAR_EVEN_GEN,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_par,
    output logic              busy
);

    localparam int                 c_CNT_W   = cnt_width(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(DATA_W - 1);
    localparam logic               c_PAR_INV = (PAR_ODD != PAR_EVEN_GEN);

    state_e             r_state;
    state_e             w_state_n;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_n;
    logic               r_parity;
    logic               r_tx_bit;
    logic               r_tx_valid;
    logic               r_tx_par;
    logic               w_tx_bit_n;
    logic               w_tx_valid_n;
    logic               w_tx_par_n;
    logic               w_xfer;
    logic               w_shift;
    logic               w_load_bit;
    logic               w_head;

    // Ready is a pure function of state; it never looks at in_valid.
    assign in_ready = (r_state != DATA);
    assign busy     = (r_state == DATA) || (r_state == PARITY);
    assign w_xfer   = in_valid && in_ready;

    assign tx_bit   = r_tx_bit;
    assign tx_valid = r_tx_valid;
    assign tx_par   = r_tx_par;

    parity_shift_reg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (w_xfer),
        .shift    (w_shift),
        .din      (in_data),
        .load_bit (w_load_bit),
        .head     (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_parity   <= 1'b0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_par   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_valid <= w_tx_valid_n;
            r_tx_par   <= w_tx_par_n;
            // Parity is taken from the whole word at load time, so it does
            // not depend on the shifting path at all.
            if (w_xfer) begin
                r_parity <= (^in_data) ^ c_PAR_INV;
            end
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_shift      = 1'b0;
        w_tx_bit_n   = 1'b0;
        w_tx_valid_n = 1'b0;
        w_tx_par_n   = 1'b0;

        case (r_state)
            DATA: begin
                w_shift = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_n = PARITY;
                end else begin
                    w_cnt_n = r_cnt + c_CNT_W'(1);
                end
            end
            PARITY: begin
                if (w_xfer) begin
                    w_state_n = DATA;
                    w_cnt_n   = '0;
                end else begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                // IDLE, and the unused 2'b11 code which behaves as IDLE.
                if (w_xfer) begin
                    w_state_n = DATA;
                    w_cnt_n   = '0;
                end else begin
                    w_state_n = IDLE;
                end
            end
        endcase

        // Outputs are registered, so they are chosen from the state being
        // entered: a fresh word puts its first bit on the line immediately
        // after the accepting edge; otherwise the stored head bit follows.
        case (w_state_n)
            DATA: begin
                w_tx_valid_n = 1'b1;
                w_tx_bit_n   = w_xfer ? w_load_bit : w_head;
            end
            PARITY: begin
                w_tx_valid_n = 1'b1;
                w_tx_par_n   = 1'b1;
                w_tx_bit_n   = r_parity;
            end
            default: begin
                w_tx_valid_n = 1'b0;
            end
        endcase
    end

endmodule : parity_serial_tx
`default_nettype wire

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
- Transmit end of the serial odd-parity frame link.
- Accepts a parallel data word through a valid/ready handshake.
- Shifts the word out one bit per clock, then appends one parity bit.
- Default frame: 3 data bits + 1 parity bit = 4 cycles, the same framing the serial parity checker consumes.

Parameters:
- DATA_W, 3: data bits per frame. Legal range 1..16.
- PAR_ODD, 0: 0 → parity bit = XOR of the data bits. 1 → parity bit = inverted XOR.
- MSB_FIRST, 0: 0 → data bit 0 is sent first. 1 → data bit DATA_W-1 is sent first.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- tx_bit  output  1  serial line.
- tx_valid  output  1  tx_bit carries a frame bit this cycle.
- tx_par  output  1  current tx_bit is the parity bit.
- busy  output  1  frame in progress (tx_valid, or a word is loaded).

Behaviour:
- Reset
  - Synchronous, active-high. Applies to all state on the next rising edge.
  - After reset: state=IDLE, tx_bit=0, tx_valid=0, tx_par=0, busy=0, in_ready=1, bit counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame. tx_valid is 0 from the first edge where reset is sampled high. No parity bit is emitted for the aborted frame.
- States: IDLE, DATA, PARITY.
- Handshake
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is combinational: in_ready = (state==IDLE) || (state==PARITY).
  - in_data is captured into the shift register, and the running parity is computed from it.
  - in_data may change freely after the accepting edge.
- Transitions
  - IDLE → DATA on a transfer.
  - DATA: emits one data bit per cycle; counter runs 0..DATA_W-1. At count DATA_W-1 → PARITY.
  - PARITY: emits the parity bit for exactly one cycle. If a transfer occurs this cycle → DATA (back-to-back, no gap). Otherwise → IDLE.
  - DATA ignores in_valid (in_ready=0).
- Latency
  - First data bit appears on tx_bit the cycle after the accepting edge.
  - Frame occupies DATA_W+1 consecutive tx_valid cycles.
  - Sustained throughput: one word per DATA_W+1 cycles.
- Outputs by state
  - IDLE: tx_valid=0, tx_bit=0, tx_par=0.
  - DATA: tx_valid=1, tx_par=0, tx_bit = current shift bit.
  - PARITY: tx_valid=1, tx_par=1, tx_bit = (^word) ^ PAR_ODD.
  - tx_bit, tx_valid and tx_par are registered outputs; none is a combinational function of the inputs.
- Shift register: shifts right (LSB-first) or left (MSB-first) after each data bit.
- Counter width: max(1, $clog2(DATA_W)). Reset to 0 on entry to DATA. Never wraps past DATA_W-1.
- DATA_W=1: DATA lasts one cycle, then PARITY.
- in_valid held high continuously: frames stream with no idle cycle between them.
- Parity computation
  - Computed once at load from in_data, not accumulated from the shifted bits.
  - Parity of all-zero data with PAR_ODD=0 is 0.

Decomposition:
- Shared package parity_link_pkg holds:
  - state enum {IDLE, DATA, PARITY}, 2-bit encoding 00/01/10, with 11 decoding to IDLE;
  - the default frame width constant FRAME_DATA_W=3;
  - the parity-mode constants PAR_EVEN_GEN=0 and PAR_ODD_GEN=1.
- The same package is used by the serial checker side.
- One natural sub-module: parity_shift_reg (load / shift / direction), DATA_W-parameterised. FSM and counter stay in the top level.

Test Plan:
- Reset then idle, in_valid=0 for 10 cycles → tx_valid=0, in_ready=1, tx_bit=0 throughout.
- DATA_W=3, PAR_ODD=0, LSB-first, send 3'b110 → tx_bit sequence 0,1,1 then parity 0 with tx_par=1; tx_valid high for exactly 4 cycles starting 1 cycle after accept.
- Send 3'b100 → bits 0,0,1, parity 1. Repeat with PAR_ODD=1 → parity 0. Repeat with MSB_FIRST=1 → bits 1,0,0.
- in_valid held high with words 3'b111, 3'b000, 3'b011 → 12 contiguous tx_valid cycles: 1,1,1,1 | 0,0,0,0 | 1,1,0,0; in_ready high only in IDLE and the parity cycles.
- Accept 3'b101, assert reset during the 2nd data bit → tx_valid=0 from the next cycle, no parity bit; the next word 3'b001 then transmits cleanly as 1,0,0,1.
- Loopback: connect to the serial checker, drive all 8 values of a 3-bit word → checker's p equals the transmitted parity bit for every frame.
